test_ram_64: RTL and testbench

TEST_RAM_64 -- requirements
Module: test_ram_64

---
 rtl/test_ram_pkg.sv | 10 +
 rtl/test_ram_64_if.sv | 31 +++
 rtl/test_ram_64.sv | 49 ++++
 tb/tb_test_ram_64.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/test_ram_pkg.sv
// Shared constants for the 64-bit test RAM: word/address widths,
// default depth and the number of byte-offset bits inside a word.
package test_ram_pkg;

  localparam int RamDataWidth    = 64;
  localparam int RamAddrWidth    = 64;
  localparam int RamNumWords     = 16;
  localparam int ByteOffsetWidth = 3;

endpackage : test_ram_pkg

// File: rtl/test_ram_64_if.sv
// Request/response bus of the 64-bit test RAM.
// master drives the request, slave (the RAM) returns registered read data.
interface test_ram_64_if
  import test_ram_pkg::*;
#(
  parameter int AddrWidth = RamAddrWidth
);

  logic                    req_i;
  logic                    we_i;
  logic [AddrWidth-1:0]    addr_i;
  logic [RamDataWidth-1:0] wdata_i;
  logic [RamDataWidth-1:0] rdata_o;

  modport master (
    output req_i,
    output we_i,
    output addr_i,
    output wdata_i,
    input  rdata_o
  );

  modport slave (
    input  req_i,
    input  we_i,
    input  addr_i,
    input  wdata_i,
    output rdata_o
  );

endinterface : test_ram_64_if

// File: rtl/test_ram_64.sv
// Single-port 64-bit word RAM built from flip-flops so the whole array
// can be cleared by the asynchronous reset. Byte address in, word
// index taken just above the byte offset; upper bits alias.
// Reads have one cycle of latency and rdata holds between reads.
module test_ram_64
  import test_ram_pkg::*;
#(
  parameter int NumWords  = RamNumWords,
  parameter int DataWidth = RamDataWidth,
  parameter int AddrWidth = RamAddrWidth
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  test_ram_64_if.slave   bus
);

  localparam int IdxWidth = $clog2(NumWords);

  logic [DataWidth-1:0] mem [NumWords];
  logic [DataWidth-1:0] rdata_q;
  logic [IdxWidth-1:0]  idx;
  logic                 addr_unused;

  // Word index: byte offset dropped, bits above the index ignored.
  assign idx = bus.addr_i[ByteOffsetWidth +: IdxWidth];

  // Offset and alias bits deliberately take no part in addressing.
  assign addr_unused = ^{bus.addr_i[AddrWidth-1:ByteOffsetWidth+IdxWidth],
                         bus.addr_i[ByteOffsetWidth-1:0]};

  // Storage and read register; reset wipes everything without a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      for (int i = 0; i < NumWords; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.req_i) begin
      if (bus.we_i) begin
        mem[idx] <= bus.wdata_i;
      end else begin
        rdata_q <= mem[idx];
      end
    end
  end

  assign bus.rdata_o = rdata_q;

endmodule : test_ram_64

// File: tb/tb_test_ram_64.sv
// Directed self-checking bench for test_ram_64 (NumWords = 16).
module tb_test_ram_64;
  import test_ram_pkg::*;

  logic clk_i;
  logic rst_ni;
  int   checks;
  int   errors;

  test_ram_64_if #(.AddrWidth(RamAddrWidth)) bus ();

  test_ram_64 #(
    .NumWords (16),
    .DataWidth(RamDataWidth),
    .AddrWidth(RamAddrWidth)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time-unit period.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not end, limit %0d time units reached", 100000);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // One request for exactly one rising edge, then back to idle.
  task automatic applyStimulus(input logic req, input logic we,
                               input logic [63:0] addr, input logic [63:0] wdata);
    @(negedge clk_i);
    bus.req_i   = req;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
    @(posedge clk_i);
    #1;
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
    end
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_ni      = 1'b0;
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b1;
    bus.addr_i  = 64'h8;
    bus.wdata_i = 64'hFFFF_FFFF_FFFF_FFFF;

    // Requests presented during reset must be ignored.
    idleCycles(3);
    checkOutput("reset_rdata", bus.rdata_o, 64'h0);

    @(negedge clk_i);
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
    rst_ni    = 1'b1;

    applyStimulus(1'b1, 1'b0, 64'h8, 64'h0);
    checkOutput("post_reset_read", bus.rdata_o, 64'h0);

    applyStimulus(1'b1, 1'b1, 64'h8, 64'h0123_4567_89AB_CDEF);
    checkOutput("write_no_rdata", bus.rdata_o, 64'h0);
    applyStimulus(1'b1, 1'b0, 64'h8, 64'h0);
    checkOutput("write_read", bus.rdata_o, 64'h0123_4567_89AB_CDEF);

    applyStimulus(1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF_0000_0001);
    checkOutput("gated_hold", bus.rdata_o, 64'h0123_4567_89AB_CDEF);
    applyStimulus(1'b1, 1'b0, 64'h10, 64'h0);
    checkOutput("gated_write", bus.rdata_o, 64'h0);

    applyStimulus(1'b1, 1'b1, 64'h80, 64'hA5A5);
    applyStimulus(1'b1, 1'b0, 64'h0, 64'h0);
    checkOutput("alias_0x80", bus.rdata_o, 64'hA5A5);
    applyStimulus(1'b1, 1'b0, 64'h0F, 64'h0);
    checkOutput("offset_0x0F", bus.rdata_o, 64'h0123_4567_89AB_CDEF);

    idleCycles(3);
    checkOutput("hold_idle", bus.rdata_o, 64'h0123_4567_89AB_CDEF);
    applyStimulus(1'b1, 1'b1, 64'h18, 64'h5555_AAAA_5555_AAAA);
    checkOutput("hold_write", bus.rdata_o, 64'h0123_4567_89AB_CDEF);
    applyStimulus(1'b1, 1'b0, 64'h1F, 64'h0);
    checkOutput("read_0x1F", bus.rdata_o, 64'h5555_AAAA_5555_AAAA);
    applyStimulus(1'b1, 1'b0, 64'h8000_0000_0000_0018, 64'h0);
    checkOutput("alias_high", bus.rdata_o, 64'h5555_AAAA_5555_AAAA);

    applyStimulus(1'b1, 1'b1, 64'h78, 64'hFEDC_BA98_7654_3210);
    applyStimulus(1'b1, 1'b0, 64'hFF, 64'h0);
    checkOutput("last_word_alias", bus.rdata_o, 64'hFEDC_BA98_7654_3210);

    applyStimulus(1'b1, 1'b1, 64'h8, 64'h1);
    applyStimulus(1'b1, 1'b0, 64'h8, 64'h0);
    checkOutput("pre_reset_read", bus.rdata_o, 64'h1);

    // Pulse reset between edges with a read already on the bus.
    @(negedge clk_i);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = 64'h78;
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_reset", bus.rdata_o, 64'h0);
    @(posedge clk_i);
    #1;
    checkOutput("reset_inflight", bus.rdata_o, 64'h0);

    // First edge after release must accept the request.
    @(negedge clk_i);
    rst_ni      = 1'b1;
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b1;
    bus.addr_i  = 64'h10;
    bus.wdata_i = 64'h77;
    @(posedge clk_i);
    #1;
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
    applyStimulus(1'b1, 1'b0, 64'h10, 64'h0);
    checkOutput("first_edge_write", bus.rdata_o, 64'h77);

    applyStimulus(1'b1, 1'b0, 64'h8, 64'h0);
    checkOutput("cleared_word1", bus.rdata_o, 64'h0);
    applyStimulus(1'b1, 1'b0, 64'h78, 64'h0);
    checkOutput("cleared_word15", bus.rdata_o, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_test_ram_64
